// File: rtl/param_data_memory_if.sv
// Request/response bus for param_data_memory: valid/ready request channel,
// one-cycle registered response, and the clear-sweep control pair.
interface param_data_memory_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  clear;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  clearing;

    // Requester side (datapath MEM stage)
    modport master (
        output clear, req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, clearing
    );

    // Memory side
    modport slave (
        input  clear, req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, clearing
    );
endinterface

// File: rtl/param_data_memory.sv
// Single-port synchronous data memory with a valid/ready request channel,
// a 1-cycle registered response, a hardware clear sweep (after reset and on
// demand) and out-of-range address error flagging.
module param_data_memory #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DEPTH       = 2**ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input logic                 clk,
    input logic                 rst,    // asynchronous, active-low
    param_data_memory_if.slave  bus
);

    localparam int                   CW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]        LAST_ADDR = CW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]  DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         clr_addr_q, clr_addr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  in_range;
    logic [CW-1:0]         req_idx;
    logic                  mem_we;
    logic [CW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // A clear request in the same cycle blocks any incoming request
    assign bus.req_ready = (state_q == ST_IDLE) && !bus.clear;
    assign bus.clearing  = (state_q == ST_CLEAR);
    assign accept        = bus.req_valid && bus.req_ready;
    assign in_range      = {1'b0, bus.req_addr} < DEPTH_EXT;
    assign req_idx       = bus.req_addr[CW-1:0];

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Next-state, sweep counter, single write port mux and response data
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        mem_we      = 1'b0;
        mem_waddr   = clr_addr_q;
        mem_wdata   = CLEAR_VALUE;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                // The sweep word is written even when a restart is requested
                mem_we = 1'b1;
                if (bus.clear) begin
                    clr_addr_d = '0;
                end else if (clr_addr_q == LAST_ADDR) begin
                    clr_addr_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase

        // accept is only possible in IDLE, so it never collides with the sweep write
        if (accept) begin
            rsp_valid_d = 1'b1;
            if (!in_range) begin
                rsp_err_d = 1'b1;
            end else if (bus.req_write) begin
                mem_we    = 1'b1;
                mem_waddr = req_idx;
                mem_wdata = bus.req_wdata;
            end else begin
                rsp_rdata_d = mem[req_idx];
            end
        end
    end

    // Control and response registers; reset restarts the sweep from address 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage array; contents are initialised only by the clear sweep
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench for param_data_memory: a 256-word instance and a 200-word
// instance share clock and reset; table vectors plus hand-written sequences
// for the clear sweep, restart and reset corner cases.
module tb_param_data_memory;

    logic clk = 1'b0;
    logic rst;

    param_data_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) ifa ();
    param_data_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) ifb ();

    param_data_memory #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .CLEAR_VALUE(8'h00)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    param_data_memory #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .CLEAR_VALUE(8'h00)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         use_b;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;

    vec_t vt [18];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit use_b, input logic v, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        if (use_b) begin
            ifb.req_valid = v; ifb.req_write = w; ifb.req_addr = a; ifb.req_wdata = d;
        end else begin
            ifa.req_valid = v; ifa.req_write = w; ifa.req_addr = a; ifa.req_wdata = d;
        end
    endtask

    // Back-to-back accepts: each vector is presented on the edge after the previous one
    task automatic run_vecs(input bit use_b, input int lo, input int hi);
        logic       v, e, rdy;
        logic [7:0] r;
        for (int i = lo; i <= hi; i++) begin
            drive(use_b, 1'b1, vt[i].wr, vt[i].addr, vt[i].wdata);
            #1;
            rdy = use_b ? ifb.req_ready : ifa.req_ready;
            chk($sformatf("vec%0d ready", i), 32'(rdy), 32'd1);
            step();
            v = use_b ? ifb.rsp_valid : ifa.rsp_valid;
            r = use_b ? ifb.rsp_rdata : ifa.rsp_rdata;
            e = use_b ? ifb.rsp_err   : ifa.rsp_err;
            chk($sformatf("vec%0d rsp_valid", i), 32'(v), 32'd1);
            chk($sformatf("vec%0d rsp_rdata", i), 32'(r), 32'(vt[i].exp_rdata));
            chk($sformatf("vec%0d rsp_err", i),   32'(e), 32'(vt[i].exp_err));
        end
        drive(use_b, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        v = use_b ? ifb.rsp_valid : ifa.rsp_valid;
        r = use_b ? ifb.rsp_rdata : ifa.rsp_rdata;
        e = use_b ? ifb.rsp_err   : ifa.rsp_err;
        chk("idle rsp_valid", 32'(v), 32'd0);
        chk("idle rsp_rdata", 32'(r), 32'd0);
        chk("idle rsp_err",   32'(e), 32'd0);
    endtask

    initial begin
        int na, nb, n, sawv;

        //            b     wr    addr   wdata  rdata  err
        vt[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 8'hFF, 8'h5A, 8'h00, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h5A, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 8'hFE, 8'h00, 8'h00, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 8'h05, 8'h3C, 8'h00, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 8'h05, 8'h00, 8'h3C, 1'b0};
        vt[10] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
        vt[11] = '{1'b1, 1'b1, 8'hC8, 8'h77, 8'h00, 1'b1};
        vt[12] = '{1'b1, 1'b0, 8'hC8, 8'h00, 8'h00, 1'b1};
        vt[13] = '{1'b1, 1'b0, 8'hC7, 8'h00, 8'h00, 1'b0};
        vt[14] = '{1'b1, 1'b1, 8'hC7, 8'h11, 8'h00, 1'b0};
        vt[15] = '{1'b1, 1'b0, 8'hC7, 8'h00, 8'h11, 1'b0};
        vt[16] = '{1'b1, 1'b1, 8'hFF, 8'h22, 8'h00, 1'b1};
        vt[17] = '{1'b1, 1'b0, 8'hC7, 8'h00, 8'h11, 1'b0};

        rst = 1'b0;
        ifa.clear = 1'b0; ifb.clear = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

        // Reset state
        #3;
        chk("rst rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        chk("rst rsp_rdata", 32'(ifa.rsp_rdata), 32'd0);
        chk("rst rsp_err",   32'(ifa.rsp_err),   32'd0);
        chk("rst clearing",  32'(ifa.clearing),  32'd1);
        chk("rst req_ready", 32'(ifa.req_ready), 32'd0);
        step();
        step();
        rst = 1'b1;

        // Sweep length after reset release: 256 words for A, 200 for B
        na = -1; nb = -1;
        for (int k = 1; k <= 400 && (na < 0 || nb < 0); k++) begin
            step();
            if (na < 0 && ifa.req_ready) na = k;
            if (nb < 0 && ifb.req_ready) nb = k;
        end
        chk("sweep len a", 32'(na), 32'd256);
        chk("sweep len b", 32'(nb), 32'd200);
        chk("clearing done a", 32'(ifa.clearing), 32'd0);

        run_vecs(1'b0, 0, 10);
        run_vecs(1'b1, 11, 17);

        // Clear with a request in the same cycle: blocked, then full sweep
        drive(1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
        ifa.clear = 1'b1;
        #1;
        chk("clr blocks ready", 32'(ifa.req_ready), 32'd0);
        step();
        ifa.clear = 1'b0;
        chk("clr no rsp", 32'(ifa.rsp_valid), 32'd0);
        chk("clr clearing", 32'(ifa.clearing), 32'd1);
        n = 0; sawv = 0;
        while (ifa.clearing && n < 400) begin
            drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(1, 255)));
            step();
            if (ifa.rsp_valid) sawv++;
            n++;
        end
        chk("clr sweep len", 32'(n), 32'd256);
        chk("clr rsp during sweep", 32'(sawv), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
        #1;
        chk("first idle ready", 32'(ifa.req_ready), 32'd1);
        step();
        chk("first accept valid", 32'(ifa.rsp_valid), 32'd1);
        chk("cleared 05 rdata",   32'(ifa.rsp_rdata), 32'd0);
        chk("cleared 05 err",     32'(ifa.rsp_err),   32'd0);

        // Async reset while a read response is being presented
        drive(1'b0, 1'b1, 1'b1, 8'h10, 8'hA5);
        step();
        drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("pre-rst rdata", 32'(ifa.rsp_rdata), 32'hA5);
        rst = 1'b0;
        #1;
        chk("async rst valid", 32'(ifa.rsp_valid), 32'd0);
        chk("async rst rdata", 32'(ifa.rsp_rdata), 32'd0);
        chk("async rst clearing", 32'(ifa.clearing), 32'd1);
        chk("async rst ready", 32'(ifa.req_ready), 32'd0);
        step();
        rst = 1'b1;

        // Reset mid-sweep at clr_addr=100 restarts a full sweep
        for (int k = 0; k < 100; k++) step();
        chk("mid sweep clearing", 32'(ifa.clearing), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid rst clearing", 32'(ifa.clearing), 32'd1);
        step();
        rst = 1'b1;
        n = 0;
        while (!ifa.req_ready && n < 400) begin
            step();
            n++;
        end
        chk("rst restart len", 32'(n), 32'd256);

        // Clear at clr_addr=50 restarts the count at 0
        ifa.clear = 1'b1;
        step();
        ifa.clear = 1'b0;
        for (int k = 0; k < 50; k++) step();
        ifa.clear = 1'b1;
        step();
        ifa.clear = 1'b0;
        n = 0;
        while (ifa.clearing && n < 400) begin
            step();
            n++;
        end
        chk("clr restart len", 32'(n), 32'd256);
        drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("final read valid", 32'(ifa.rsp_valid), 32'd1);
        chk("final read rdata", 32'(ifa.rsp_rdata), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
